// File: rtl/tl_pkg.sv
// Shared transaction-layer definitions used by the flow-control state machine
// and the VC buffer bank.
package tl_pkg;

    localparam int NUM_VC   = 8;
    localparam int VC_DEPTH = 8;
    localparam int VC_AW    = 3;
    localparam int THR_W    = 3;
    localparam int CNT_W    = VC_AW + 1;

    typedef logic [VC_AW-1:0] vc_id_t;
    typedef logic [CNT_W-1:0] vc_cnt_t;

endpackage

// File: rtl/vc_fifo.sv
// Single virtual-channel FIFO: memory, wrapping pointers and occupancy count.
// Strobes arrive already qualified by the bank's accept logic.
module vc_fifo
    import tl_pkg::*;
#(
    parameter int DATA_WIDTH = 6
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  wr,
    input  logic                  rd,
    input  logic [DATA_WIDTH-1:0] wr_data,
    output logic [DATA_WIDTH-1:0] rd_data,
    output vc_cnt_t               count
);

    logic [DATA_WIDTH-1:0] mem_q [VC_DEPTH];
    logic [VC_AW-1:0]      wptr_q, wptr_d;
    logic [VC_AW-1:0]      rptr_q, rptr_d;
    vc_cnt_t               count_q, count_d;

    // NOTE: every output of a combinational block gets a default first, so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        if (wr) wptr_d = wptr_q + 1'b1;
        if (rd) rptr_d = rptr_q + 1'b1;
        unique case ({wr, rd})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // NOTE: state flops use non-blocking assignments so every flop samples
    // the pre-edge values regardless of process evaluation order.
    always_ff @(posedge clk) begin
        if (reset) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
        end
    end

    // NOTE: the storage array is deliberately not reset; a zero count makes
    // stale contents unreachable, and leaving it out keeps it a plain RAM.
    always_ff @(posedge clk) begin
        if (wr) mem_q[wptr_q] <= wr_data;
    end

    assign rd_data = mem_q[rptr_q];
    assign count   = count_q;

endmodule

// File: rtl/vc_buffer_bank.sv
// Eight-VC ingress buffer bank: per-VC FIFOs, accept logic, registered read
// port, threshold-based flow-control flags and sticky error flags.
module vc_buffer_bank
    import tl_pkg::*;
#(
    parameter int DATA_WIDTH = 6,
    parameter int DEPTH      = VC_DEPTH
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  push,
    input  vc_id_t                push_vc,
    input  logic [DATA_WIDTH-1:0] push_data,
    input  logic                  pop,
    input  vc_id_t                pop_vc,
    input  logic [THR_W-1:0]      umbral_superior,
    input  logic [THR_W-1:0]      umbral_inferior,
    output logic [DATA_WIDTH-1:0] pop_data,
    output logic                  pop_valid,
    output logic [NUM_VC-1:0]     empty,
    output logic [NUM_VC-1:0]     full,
    output logic [NUM_VC-1:0]     almost_full,
    output logic [NUM_VC-1:0]     almost_empty,
    output logic                  err_overflow,
    output logic                  err_underflow
);

    localparam vc_cnt_t DEPTH_C = vc_cnt_t'(DEPTH);

    vc_cnt_t               count   [NUM_VC];
    logic [DATA_WIDTH-1:0] rd_data [NUM_VC];
    logic [NUM_VC-1:0]     wr_en, rd_en;
    logic                  pop_ok, push_ok;

    logic [DATA_WIDTH-1:0] pop_data_q, pop_data_d;
    logic                  pop_valid_q, pop_valid_d;
    logic                  err_overflow_q, err_overflow_d;
    logic                  err_underflow_q, err_underflow_d;
    vc_cnt_t               af_level;

    // A full VC still takes a push when the same VC is drained this cycle.
    always_comb begin
        pop_ok  = pop && (count[pop_vc] != '0);
        push_ok = push && ((count[push_vc] != DEPTH_C) ||
                           (pop_ok && (pop_vc == push_vc)));
        wr_en   = '0;
        rd_en   = '0;
        wr_en[push_vc] = push_ok;
        rd_en[pop_vc]  = pop_ok;
    end

    for (genvar g = 0; g < NUM_VC; g++) begin : g_vc
        vc_fifo #(
            .DATA_WIDTH (DATA_WIDTH)
        ) u_fifo (
            .clk     (clk),
            .reset   (reset),
            .wr      (wr_en[g]),
            .rd      (rd_en[g]),
            .wr_data (push_data),
            .rd_data (rd_data[g]),
            .count   (count[g])
        );
    end

    always_comb begin
        pop_valid_d     = pop_ok;
        pop_data_d      = pop_ok ? rd_data[pop_vc] : pop_data_q;
        err_overflow_d  = err_overflow_q  | (push & ~push_ok);
        err_underflow_d = err_underflow_q | (pop & ~pop_ok);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pop_data_q      <= '0;
            pop_valid_q     <= 1'b0;
            err_overflow_q  <= 1'b0;
            err_underflow_q <= 1'b0;
        end else begin
            pop_data_q      <= pop_data_d;
            pop_valid_q     <= pop_valid_d;
            err_overflow_q  <= err_overflow_d;
            err_underflow_q <= err_underflow_d;
        end
    end

    // Thresholds widen to 4 bits so DEPTH - umbral_superior spans 1..8.
    always_comb begin
        af_level = DEPTH_C - vc_cnt_t'(umbral_superior);
        for (int i = 0; i < NUM_VC; i++) begin
            empty[i]        = (count[i] == '0);
            full[i]         = (count[i] == DEPTH_C);
            almost_full[i]  = (count[i] >= af_level);
            almost_empty[i] = (count[i] <= vc_cnt_t'(umbral_inferior));
        end
    end

    assign pop_data      = pop_data_q;
    assign pop_valid     = pop_valid_q;
    assign err_overflow  = err_overflow_q;
    assign err_underflow = err_underflow_q;

endmodule

// File: tb/tb_vc_buffer_bank.sv
// Self-checking bench for vc_buffer_bank: a table of vectors, hand-written
// corner sequences, and a reference model with a read-data scoreboard.
module tb_vc_buffer_bank;

    logic       clk = 1'b0;
    logic       reset;
    logic       push;
    logic [2:0] push_vc;
    logic [5:0] push_data;
    logic       pop;
    logic [2:0] pop_vc;
    logic [2:0] umbral_superior;
    logic [2:0] umbral_inferior;
    logic [5:0] pop_data;
    logic       pop_valid;
    logic [7:0] empty, full, almost_full, almost_empty;
    logic       err_overflow, err_underflow;

    vc_buffer_bank #(.DATA_WIDTH(6), .DEPTH(8)) dut (
        .clk             (clk),
        .reset           (reset),
        .push            (push),
        .push_vc         (push_vc),
        .push_data       (push_data),
        .pop             (pop),
        .pop_vc          (pop_vc),
        .umbral_superior (umbral_superior),
        .umbral_inferior (umbral_inferior),
        .pop_data        (pop_data),
        .pop_valid       (pop_valid),
        .empty           (empty),
        .full            (full),
        .almost_full     (almost_full),
        .almost_empty    (almost_empty),
        .err_overflow    (err_overflow),
        .err_underflow   (err_underflow)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // reference model state
    int         m_cnt [8];
    int         m_rp  [8];
    int         m_wp  [8];
    logic [5:0] m_mem [8][8];
    bit         m_ovf, m_unf, m_valid;
    logic [5:0] m_last;
    logic [5:0] exp_q [$];

    typedef struct {
        bit         ps;
        int         pv;
        logic [5:0] pd;
        bit         pp;
        int         ov;
        bit         exp_valid;
        logic [5:0] exp_data;
        logic [7:0] exp_empty;
    } vec_t;

    vec_t vecs [7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    task automatic model_reset();
        for (int i = 0; i < 8; i++) begin
            m_cnt[i] = 0;
            m_rp[i]  = 0;
            m_wp[i]  = 0;
        end
        m_ovf   = 1'b0;
        m_unf   = 1'b0;
        m_valid = 1'b0;
        m_last  = '0;
        exp_q.delete();
    endtask

    task automatic model_update(input bit ps, input int pv, input logic [5:0] pd,
                                input bit pp, input int ov);
        bit pa, wa;
        pa = pp && (m_cnt[ov] != 0);
        wa = ps && ((m_cnt[pv] != 8) || (pa && (ov == pv)));
        if (pp && !pa) m_unf = 1'b1;
        if (ps && !wa) m_ovf = 1'b1;
        m_valid = pa;
        if (pa) begin
            exp_q.push_back(m_mem[ov][m_rp[ov]]);
            m_rp[ov] = (m_rp[ov] + 1) % 8;
            m_cnt[ov]--;
        end
        if (wa) begin
            m_mem[pv][m_wp[pv]] = pd;
            m_wp[pv] = (m_wp[pv] + 1) % 8;
            m_cnt[pv]++;
        end
    endtask

    task automatic check_outputs();
        logic [7:0] e, f, af, ae;
        for (int i = 0; i < 8; i++) begin
            e[i]  = (m_cnt[i] == 0);
            f[i]  = (m_cnt[i] == 8);
            af[i] = (m_cnt[i] >= 8 - int'(umbral_superior));
            ae[i] = (m_cnt[i] <= int'(umbral_inferior));
        end
        check("empty", empty, e);
        check("full", full, f);
        check("almost_full", almost_full, af);
        check("almost_empty", almost_empty, ae);
        check("err_overflow", err_overflow, m_ovf);
        check("err_underflow", err_underflow, m_unf);
        check("pop_valid", pop_valid, m_valid);
        if (m_valid && exp_q.size() != 0) m_last = exp_q.pop_front();
        check("pop_data", pop_data, m_last);
    endtask

    // Called at a negedge; returns at the following negedge with outputs checked.
    task automatic step(input bit ps, input int pv, input logic [5:0] pd,
                        input bit pp, input int ov);
        push      = ps;
        push_vc   = pv[2:0];
        push_data = pd;
        pop       = pp;
        pop_vc    = ov[2:0];
        @(posedge clk);
        model_update(ps, pv, pd, pp, ov);
        @(negedge clk);
        push = 1'b0;
        pop  = 1'b0;
        check_outputs();
    endtask

    task automatic do_reset(input bit ps, input int pv);
        reset     = 1'b1;
        push      = ps;
        push_vc   = pv[2:0];
        push_data = 6'h3C;
        pop       = ps;
        pop_vc    = pv[2:0];
        @(posedge clk);
        model_reset();
        @(negedge clk);
        reset = 1'b0;
        push  = 1'b0;
        pop   = 1'b0;
        check("rst_empty", empty, 8'hFF);
        check("rst_full", full, 8'h00);
        check("rst_almost_empty", almost_empty, 8'hFF);
        check("rst_almost_full", almost_full, 8'h00);
        check("rst_pop_valid", pop_valid, 1'b0);
        check("rst_pop_data", pop_data, 6'h00);
        check("rst_err_overflow", err_overflow, 1'b0);
        check("rst_err_underflow", err_underflow, 1'b0);
    endtask

    initial begin
        reset = 1'b1; push = 1'b0; pop = 1'b0;
        push_vc = '0; pop_vc = '0; push_data = '0;
        umbral_superior = 3'd2;
        umbral_inferior = 3'd1;
        model_reset();

        // expected pop_valid/pop_data/empty hand-derived for the VC3 sequence
        vecs[0] = '{1, 3, 6'h11, 0, 0, 0, 6'h00, 8'hF7};
        vecs[1] = '{1, 3, 6'h22, 0, 0, 0, 6'h00, 8'hF7};
        vecs[2] = '{1, 3, 6'h33, 0, 0, 0, 6'h00, 8'hF7};
        vecs[3] = '{0, 0, 6'h00, 1, 3, 1, 6'h11, 8'hF7};
        vecs[4] = '{0, 0, 6'h00, 1, 3, 1, 6'h22, 8'hF7};
        vecs[5] = '{0, 0, 6'h00, 1, 3, 1, 6'h33, 8'hFF};
        vecs[6] = '{0, 0, 6'h00, 0, 0, 0, 6'h33, 8'hFF};

        @(negedge clk);
        do_reset(1'b0, 0);
        step(0, 0, 6'h00, 0, 0);

        foreach (vecs[k]) begin
            step(vecs[k].ps, vecs[k].pv, vecs[k].pd, vecs[k].pp, vecs[k].ov);
            check("vec_pop_valid", pop_valid, vecs[k].exp_valid);
            check("vec_pop_data", pop_data, vecs[k].exp_data);
            check("vec_empty", empty, vecs[k].exp_empty);
        end

        // fill VC5 and watch almost_full / full rise
        for (int i = 1; i <= 8; i++) begin
            step(1, 5, 6'(i * 5 + 1), 0, 0);
            check("vc5_almost_full", almost_full[5], (i >= 6));
            check("vc5_full", full[5], (i == 8));
        end
        step(1, 5, 6'h2F, 0, 0);
        check("vc5_overflow", err_overflow, 1'b1);
        check("vc5_full_after_ovf", full[5], 1'b1);
        step(1, 5, 6'h3F, 1, 5);
        check("vc5_pushpop_full", full[5], 1'b1);
        check("vc5_pushpop_data", pop_data, 6'h06);
        for (int t = 0; t < 8; t++) begin
            umbral_superior = 3'(t);
            umbral_inferior = 3'(7 - t);
            step(0, 0, 6'h00, 0, 0);
        end
        umbral_superior = 3'd2;
        umbral_inferior = 3'd1;
        for (int i = 0; i < 8; i++) step(0, 0, 6'h00, 1, 5);
        check("vc5_last_word", pop_data, 6'h3F);
        check("vc5_drained", empty[5], 1'b1);

        // pop from empty VC0 with a simultaneous push to it
        step(1, 0, 6'h2A, 1, 0);
        check("vc0_underflow", err_underflow, 1'b1);
        check("vc0_no_valid", pop_valid, 1'b0);
        check("vc0_not_empty", empty[0], 1'b0);
        step(0, 0, 6'h00, 1, 0);
        check("vc0_data", pop_data, 6'h2A);

        // independent push and pop on different VCs
        step(1, 6, 6'h15, 0, 0);
        step(1, 1, 6'h09, 1, 6);
        check("diff_empty6", empty[6], 1'b1);
        check("diff_empty1", empty[1], 1'b0);
        check("diff_valid", pop_valid, 1'b1);
        check("diff_data", pop_data, 6'h15);
        step(0, 0, 6'h00, 1, 1);

        // reset with data buffered in VC7 discards it
        for (int i = 0; i < 4; i++) step(1, 7, 6'(6'h30 + i), 0, 0);
        check("vc7_loaded", empty[7], 1'b0);
        do_reset(1'b1, 7);
        step(0, 0, 6'h00, 1, 7);
        check("vc7_underflow", err_underflow, 1'b1);
        check("vc7_no_valid", pop_valid, 1'b0);

        // random mixed traffic against the model
        for (int i = 0; i < 300; i++) begin
            step(1'($urandom_range(0, 1)), int'($urandom_range(0, 7)), 6'($urandom),
                 1'($urandom_range(0, 1)), int'($urandom_range(0, 7)));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/vc_buffer_bank.md
# vc_buffer_bank

Eight-virtual-channel buffer bank at the transaction-layer ingress, on the producer side of the flow-control state machine. It stores packets per VC in eight independent FIFOs. It generates the per-VC `empty` flags that drive the state machine's IDLE/ACTIVE decision, and it consumes that machine's latched `umbral_superior`/`umbral_inferior` thresholds to produce almost-full and almost-empty flow-control flags. Errors on overflow and underflow are flagged and sticky until reset.

## Interface
- `DATA_WIDTH`, default 6: width of one buffered word.
- `DEPTH`, default 8: entries per VC FIFO. Fixed at 8 so that the 3-bit thresholds span the full range.
- `clk` input 1: clock; all state updates on the rising edge.
- `reset` input 1: reset, synchronous, active-high; clock clk.
- `push` input 1: write request.
- `push_vc` input 3: target VC of the write.
- `push_data` input DATA_WIDTH: write word.
- `pop` input 1: read request.
- `pop_vc` input 3: source VC of the read.
- `umbral_superior` input 3: almost-full threshold, in free slots.
- `umbral_inferior` input 3: almost-empty threshold, in occupied slots.
- `pop_data` output DATA_WIDTH: registered read word.
- `pop_valid` output 1: `pop_data` is valid this cycle.
- `empty` output 8: bit i means VC i has count 0.
- `full` output 8: bit i means VC i has count DEPTH.
- `almost_full` output 8: bit i means count_i >= DEPTH - `umbral_superior`.
- `almost_empty` output 8: bit i means count_i <= `umbral_inferior`.
- `err_overflow` output 1: sticky; a push was attempted to a full VC.
- `err_underflow` output 1: sticky; a pop was attempted from an empty VC.

## Operation
- **Storage.** Each VC has its own FIFO with a 3-bit write pointer, a 3-bit read pointer and a 4-bit count (range 0..8). Pointers wrap 7→0 naturally.
- **Push.** A push with `push_vc=v` writes `push_data` at `wptr_v` and increments `wptr_v` and `count_v`. It is accepted only if VC v is not full, or if a pop to the same VC occurs in the same cycle.
- **Pop.** A pop with `pop_vc=v` is accepted only if `count_v != 0` (the registered count; no same-cycle bypass).
  - An accepted pop registers `mem_v[rptr_v]` into `pop_data`, asserts `pop_valid` next cycle, and increments `rptr_v`.
- **Same VC, same cycle.**
  - Not empty and not full: both operations are accepted and the count is unchanged.
  - Empty: the pop is rejected (underflow) and the push is accepted.
  - Full: both are accepted and the count stays 8.
- **Different VCs, same cycle:** both operations are independent and both are accepted if legal.
- **Rejected operations** leave the memory, pointers and counts untouched. A rejected push sets `err_overflow`; a rejected pop sets `err_underflow`. Both flags clear only on reset.
- **Status flags.** `empty`, `full`, `almost_full` and `almost_empty` are combinational from the registered counts and the threshold inputs.
  - The comparisons are done 4 bits wide; DEPTH - `umbral_superior` ranges 1..8.
  - `umbral_superior=0` makes `almost_full` equal to `full`.
  - `umbral_inferior=0` makes `almost_empty` equal to `empty`.
- **Thresholds** are sampled every cycle, with no internal latch; the state machine already holds them stable after INIT.

## Timing
- **Reset values:**
  - Counts and pointers are 0.
  - `empty`=8'hFF, `full`=8'h00, `almost_empty`=8'hFF, `almost_full`=8'h00 for any legal threshold.
  - `pop_data`=0, `pop_valid`=0, both error flags 0.
- **Reset mid-operation** discards all buffered data. Push and pop in the reset cycle are ignored.
- **Push latency:** a push in cycle N makes `empty[v]` deassert and the counts update in cycle N+1. The earliest pop of that word is in cycle N+1, with data in N+2.
- **Pop latency:** a pop in cycle N gives `pop_data`/`pop_valid` in cycle N+1. `pop_valid` is a single-cycle pulse per accepted pop, and `pop_data` holds its value otherwise.
- **Back-to-back pops** on one VC deliver one word per cycle, in FIFO order.

## Structure
- Shared package `tl_pkg`:
  - `NUM_VC=8`, `VC_DEPTH=8`, `VC_AW=3`, `THR_W=3`;
  - a `vc_id_t` 3-bit typedef, reused by the state machine and the bank.
- One sub-module, `vc_fifo`:
  - contains a single FIFO with its memory, pointers and count;
  - has `wr`/`rd` strobes and exposes its count;
  - is instantiated 8 times via generate.
- The top level contains:
  - VC decode of `push_vc`/`pop_vc`;
  - the accept logic;
  - the read-data mux into the `pop_data` register;
  - the threshold comparators;
  - the sticky error flags.

## Test plan
- Reset, then idle with `umbral_superior=2`, `umbral_inferior=1` → `empty`=FF, `full`=00, `almost_empty`=FF, `almost_full`=00, errors 0.
- Push 0x11,0x22,0x33 to VC3, then pop VC3 three times back-to-back → `pop_data` 0x11,0x22,0x33 on consecutive cycles with `pop_valid` high. `empty[3]` goes 1→0→1. `almost_empty[3]` is 0 only while count_3 ≥ 2.
- Fill VC5 with 8 words, `umbral_superior=2` → `almost_full[5]` asserts at count 6 and `full[5]` at count 8. A 9th push sets `err_overflow` and leaves the count at 8. A push and pop together on VC5 keep the count at 8, and the data order is preserved.
- Pop VC0 while empty, with a simultaneous push to VC0 of 0x2A → `err_underflow`=1, no `pop_valid`, count_0=1. Next cycle, pop VC0 → 0x2A.
- Push VC1 and pop VC6 (holding 1 word) in the same cycle → count_1=1, `empty[6]`=1, `pop_valid` next cycle with VC6's word.
- Assert reset with 4 words in VC7 → all flags return to their reset values, and a subsequent pop of VC7 underflows.
